// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Multi-cycle stand-in for the core's data memory. A word-addressed,
// byte-masked read or write request is accepted in IDLE, serviced after a
// programmable latency, and acknowledged with a one-cycle read_done or
// write_done pulse that releases the core's PC stall.
//
// Parameters
//   ADDR_WIDTH     word-address width, depth = 2**ADDR_WIDTH 32-bit words
//   READ_LATENCY   edges from read acceptance to read_done visible (1..15)
//   WRITE_LATENCY  edges from write acceptance to write_done visible (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   read_enable   read request, held by the core until read_done
//   write_enable  write request, held by the core until write_done
//   address       word address
//   write_data    lane-aligned store data
//   write_mask    byte-lane enables, bit i covers write_data[8i+7:8i]
//   read_data     read result, valid while read_done is high, held otherwise
//   read_done     one-cycle read completion pulse
//   write_done    one-cycle write completion pulse
// ---------------------------------------------------------------------------
module data_memory_responder #(
   parameter int ADDR_WIDTH    = 10,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_enable,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   input  logic [3:0]            write_mask,
   output logic [31:0]           read_data,
   output logic                  read_done,
   output logic                  write_done
);

   localparam int          DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [3:0]  RD_LAT = 4'(READ_LATENCY);
   localparam logic [3:0]  WR_LAT = 4'(WRITE_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   logic [31:0]           r_mem [DEPTH];

   state_t                r_state;
   logic [3:0]            r_counter;
   logic                  r_op_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wmask;
   logic [31:0]           r_read_data;

   state_t                w_state_next;
   logic                  w_accept;
   logic                  w_accept_write;
   logic [3:0]            w_latency;
   logic                  w_access;
   logic                  w_acc_write;
   logic [ADDR_WIDTH-1:0] w_acc_addr;
   logic [31:0]           w_acc_data;
   logic [3:0]            w_acc_mask;

   // Next-state and access decode. With a latency of one the access happens
   // on the acceptance edge itself, so the live inputs are used instead of
   // the (not yet loaded) latched copies.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_next   = r_state;
      w_accept       = 1'b0;
      w_accept_write = 1'b0;
      w_latency      = 4'd0;
      w_access       = 1'b0;
      w_acc_write    = r_op_write;
      w_acc_addr     = r_addr;
      w_acc_data     = r_wdata;
      w_acc_mask     = r_wmask;

      case (r_state)
         ST_IDLE: begin
            if (write_enable || read_enable) begin
               w_accept       = 1'b1;
               w_accept_write = write_enable;     // write wins over a read
               w_latency      = write_enable ? WR_LAT : RD_LAT;
               if (w_latency == 4'd1) begin
                  w_access     = 1'b1;
                  w_acc_write  = write_enable;
                  w_acc_addr   = address;
                  w_acc_data   = write_data;
                  w_acc_mask   = write_mask;
                  w_state_next = ST_RESP;
               end else begin
                  w_state_next = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (r_counter == 4'd1) begin
               w_access     = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Control state, latched request and read result.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_counter   <= 4'd0;
         r_op_write  <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_wmask     <= 4'd0;
         r_read_data <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op_write <= w_accept_write;
            r_addr     <= address;
            r_counter  <= w_latency - 4'd1;
            if (w_accept_write) begin
               r_wdata <= write_data;
               r_wmask <= write_mask;
            end
         end else if (r_state == ST_BUSY) begin
            r_counter <= r_counter - 4'd1;
         end
         if (w_access && !w_acc_write) begin
            r_read_data <= r_mem[w_acc_addr];
         end
      end
   end

   // Storage array, byte-lane writes.
   // NOTE: the array has no reset; contents survive reset, only the pending
   // access is squashed by gating with reset.
   always_ff @(posedge clk) begin
      if (!reset && w_access && w_acc_write) begin
         for (int i = 0; i < 4; i++) begin
            if (w_acc_mask[i]) begin
               r_mem[w_acc_addr][8*i +: 8] <= w_acc_data[8*i +: 8];
            end
         end
      end
   end

   assign read_data  = r_read_data;
   assign read_done  = (r_state == ST_RESP) && !r_op_write;
   assign write_done = (r_state == ST_RESP) &&  r_op_write;

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//
// Directed bench for data_memory_responder. Instance "a" uses the default
// latencies (read 2, write 1); instance "b" uses a write latency of 4 so a
// write spends several cycles in BUSY. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // instance a: READ_LATENCY=2, WRITE_LATENCY=1
   logic          a_reset, a_re, a_we;
   logic [AW-1:0] a_addr;
   logic [31:0]   a_wdata;
   logic [3:0]    a_wmask;
   logic [31:0]   a_rdata;
   logic          a_rdone, a_wdone;

   // instance b: READ_LATENCY=2, WRITE_LATENCY=4
   logic          b_reset, b_re, b_we;
   logic [AW-1:0] b_addr;
   logic [31:0]   b_wdata;
   logic [3:0]    b_wmask;
   logic [31:0]   b_rdata;
   logic          b_rdone, b_wdone;

   data_memory_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut_a (
      .clk          (clk),
      .reset        (a_reset),
      .read_enable  (a_re),
      .write_enable (a_we),
      .address      (a_addr),
      .write_data   (a_wdata),
      .write_mask   (a_wmask),
      .read_data    (a_rdata),
      .read_done    (a_rdone),
      .write_done   (a_wdone)
   );

   data_memory_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_LATENCY(4)) u_dut_b (
      .clk          (clk),
      .reset        (b_reset),
      .read_enable  (b_re),
      .write_enable (b_we),
      .address      (b_addr),
      .write_data   (b_wdata),
      .write_mask   (b_wmask),
      .read_data    (b_rdata),
      .read_done    (b_rdone),
      .write_done   (b_wdone)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bus transactions: hold the request until done, drop it in the done cycle.
   task automatic a_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int n = 0;
      a_we = 1'b1; a_addr = addr; a_wdata = data; a_wmask = mask;
      do begin step(); n++; end while (!a_wdone && n < 20);
      if (!a_wdone) begin
         n_cmp++; n_err++;
         $display("FAIL a_write_timeout addr=%0d: write_done never seen, required within 20 cycles", addr);
      end
      a_we = 1'b0;
   endtask

   task automatic a_read(input logic [AW-1:0] addr, output logic [31:0] data);
      int n = 0;
      a_re = 1'b1; a_addr = addr;
      do begin step(); n++; end while (!a_rdone && n < 20);
      if (!a_rdone) begin
         n_cmp++; n_err++;
         $display("FAIL a_read_timeout addr=%0d: read_done never seen, required within 20 cycles", addr);
      end
      data = a_rdata;
      a_re = 1'b0;
   endtask

   task automatic b_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int n = 0;
      b_we = 1'b1; b_addr = addr; b_wdata = data; b_wmask = mask;
      do begin step(); n++; end while (!b_wdone && n < 20);
      if (!b_wdone) begin
         n_cmp++; n_err++;
         $display("FAIL b_write_timeout addr=%0d: write_done never seen, required within 20 cycles", addr);
      end
      b_we = 1'b0;
   endtask

   task automatic b_read(input logic [AW-1:0] addr, output logic [31:0] data);
      int n = 0;
      b_re = 1'b1; b_addr = addr;
      do begin step(); n++; end while (!b_rdone && n < 20);
      if (!b_rdone) begin
         n_cmp++; n_err++;
         $display("FAIL b_read_timeout addr=%0d: read_done never seen, required within 20 cycles", addr);
      end
      data = b_rdata;
      b_re = 1'b0;
   endtask

   task automatic test_reset();
      a_reset = 1'b1; a_re = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0;
      b_reset = 1'b1; b_re = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;
      step(); step();
      a_reset = 1'b0; b_reset = 1'b0;
      n_cmp++;
      if ({a_rdata, a_rdone, a_wdone} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_a: got rdata=%h rdone=%b wdone=%b, required all 0", a_rdata, a_rdone, a_wdone);
      end
      n_cmp++;
      if ({b_rdata, b_rdone, b_wdone} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_b: got rdata=%h rdone=%b wdone=%b, required all 0", b_rdata, b_rdone, b_wdone);
      end
   endtask

   // Read latency 2: accepted at E1, done only in the cycle after E2.
   task automatic test_read_latency();
      a_write(10'd5, 32'hDEAD_BEEF, 4'hF);
      step();                              // E0, back in IDLE
      a_re = 1'b1; a_addr = 10'd5;
      step();                              // E1: acceptance
      n_cmp++;
      if (a_rdone !== 1'b0) begin
         n_err++; $display("FAIL rd_lat_e1: read_done=%b, required 0", a_rdone);
      end
      step();                              // E2: access
      n_cmp++;
      if (a_rdone !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL rd_lat_e2: read_done=%b data=%h, required 1 / deadbeef", a_rdone, a_rdata);
      end
      a_re = 1'b0;
      step();                              // E3
      n_cmp++;
      if (a_rdone !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL rd_lat_e3: read_done=%b data=%h, required 0 / deadbeef (held)", a_rdone, a_rdata);
      end
   endtask

   task automatic test_write_mask();
      logic [31:0] rd;
      a_write(10'd3, 32'h1122_3344, 4'hF);
      step();
      a_we = 1'b1; a_addr = 10'd3; a_wdata = 32'hAABB_CCDD; a_wmask = 4'b0101;
      step();                              // E1: acceptance and access
      n_cmp++;
      if (a_wdone !== 1'b1 || a_rdone !== 1'b0) begin
         n_err++; $display("FAIL wr_mask_e1: write_done=%b read_done=%b, required 1 / 0", a_wdone, a_rdone);
      end
      a_we = 1'b0;
      step();
      n_cmp++;
      if (a_wdone !== 1'b0) begin
         n_err++; $display("FAIL wr_mask_e2: write_done=%b, required 0", a_wdone);
      end
      a_read(10'd3, rd);
      n_cmp++;
      if (rd !== 32'h11BB_33DD) begin
         n_err++; $display("FAIL wr_mask_data: got %h, required 11bb33dd", rd);
      end
   endtask

   task automatic test_both_high();
      logic [31:0] rd;
      int wpulses = 0;
      int rpulses = 0;
      a_write(10'd7, 32'h1234_5678, 4'hF);
      step();
      a_re = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_wdata = 32'h0000_00FF; a_wmask = 4'hF;
      for (int i = 0; i < 6; i++) begin
         step();
         if (a_wdone) begin
            wpulses++;
            a_re = 1'b0; a_we = 1'b0;
         end
         if (a_rdone) rpulses++;
      end
      n_cmp++;
      if (wpulses != 1 || rpulses != 0) begin
         n_err++; $display("FAIL both_high_pulses: write=%0d read=%0d, required 1 / 0", wpulses, rpulses);
      end
      a_read(10'd7, rd);
      n_cmp++;
      if (rd !== 32'h0000_00FF) begin
         n_err++; $display("FAIL both_high_data: got %h, required 000000ff", rd);
      end
   endtask

   // read_enable held high; the "core" moves the address on each done.
   task automatic test_back_to_back();
      int          idx [2];
      logic [31:0] dat [2];
      int          n = 0;
      a_write(10'd1, 32'h0000_000A, 4'hF);
      a_write(10'd2, 32'h0000_000B, 4'hF);
      step();
      a_re = 1'b1; a_addr = 10'd1;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (a_rdone) begin
            if (n < 2) begin
               idx[n] = i; dat[n] = a_rdata;
            end
            n++;
            if (n == 1) a_addr = 10'd2;
            else        a_re = 1'b0;
         end
      end
      a_re = 1'b0;
      n_cmp++;
      if (n != 2) begin
         n_err++; $display("FAIL b2b_count: got %0d read_done pulses, required 2", n);
      end else begin
         n_cmp++;
         if (idx[1] - idx[0] != 3) begin
            n_err++; $display("FAIL b2b_spacing: got %0d cycles, required 3", idx[1] - idx[0]);
         end
         n_cmp++;
         if (dat[0] !== 32'hA || dat[1] !== 32'hB) begin
            n_err++; $display("FAIL b2b_data: got %h %h, required 0000000a 0000000b", dat[0], dat[1]);
         end
      end
   endtask

   // Enable dropped after acceptance: the read still completes.
   task automatic test_drop_enable();
      int          hits = 0;
      logic [31:0] seen = '0;
      step();
      a_re = 1'b1; a_addr = 10'd3;
      step();                              // acceptance
      a_re = 1'b0; a_addr = 10'd5;
      for (int i = 0; i < 5; i++) begin
         step();
         if (a_rdone) begin hits++; seen = a_rdata; end
      end
      n_cmp++;
      if (hits != 1 || seen !== 32'h11BB_33DD) begin
         n_err++; $display("FAIL drop_enable: pulses=%0d data=%h, required 1 / 11bb33dd", hits, seen);
      end
   endtask

   // Write latency 4, reset at the 2nd edge after acceptance.
   task automatic test_reset_in_busy();
      logic [31:0] rd;
      int          hits = 0;
      b_write(10'd9, 32'h0000_0000, 4'hF);
      b_write(10'd8, 32'h0000_0055, 4'hF);
      b_read(10'd8, rd);                   // leave read_data non-zero
      n_cmp++;
      if (rd !== 32'h55) begin
         n_err++; $display("FAIL rst_busy_pre: got %h, required 00000055", rd);
      end
      step();
      b_we = 1'b1; b_addr = 10'd9; b_wdata = 32'hCAFE_F00D; b_wmask = 4'hF;
      step();                              // acceptance
      step();                              // 1st edge after
      b_reset = 1'b1; b_we = 1'b0;
      step();                              // 2nd edge after: reset sampled
      b_reset = 1'b0;
      n_cmp++;
      if ({b_rdata, b_rdone, b_wdone} !== 34'd0) begin
         n_err++; $display("FAIL rst_busy_out: rdata=%h rdone=%b wdone=%b, required all 0", b_rdata, b_rdone, b_wdone);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (b_wdone || b_rdone) hits++;
      end
      n_cmp++;
      if (hits != 0) begin
         n_err++; $display("FAIL rst_busy_nodone: got %0d done pulses, required 0", hits);
      end
      b_read(10'd9, rd);
      n_cmp++;
      if (rd !== 32'h0) begin
         n_err++; $display("FAIL rst_busy_mem: got %h, required 00000000", rd);
      end
   endtask

   // Inputs change during BUSY; access uses latched values.
   task automatic test_busy_inputs();
      logic [31:0] rd;
      int          hits = 0;
      int          at   = 0;
      b_write(10'd4, 32'h0000_0000, 4'hF);
      b_write(10'd6, 32'h0000_0000, 4'hF);
      step();
      b_we = 1'b1; b_addr = 10'd4; b_wdata = 32'h1234_5678; b_wmask = 4'hF;
      step();                              // E1: acceptance
      b_addr = 10'd6; b_wdata = 32'h9999_9999; b_wmask = 4'h0;
      for (int i = 2; i <= 9; i++) begin
         step();
         if (b_wdone) begin
            hits++; at = i; b_we = 1'b0;
         end
      end
      b_we = 1'b0;
      n_cmp++;
      if (hits != 1 || at != 4) begin
         n_err++; $display("FAIL busy_in_pulse: pulses=%0d after edge %0d, required 1 after edge 4", hits, at);
      end
      b_read(10'd4, rd);
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_err++; $display("FAIL busy_in_addr4: got %h, required 12345678", rd);
      end
      b_read(10'd6, rd);
      n_cmp++;
      if (rd !== 32'h0) begin
         n_err++; $display("FAIL busy_in_addr6: got %h, required 00000000", rd);
      end
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_mask();
      test_both_high();
      test_back_to_back();
      test_drop_enable();
      test_reset_in_busy();
      test_busy_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
